// File: rtl/bus_cycle_responder_pkg.sv
// Shared types and constants for the 68000 bus cycle responder.
//   state_t  : responder FSM states
//   region_t : latched decoder region for the current bus cycle
//   WAIT_W / TMO_W : wait-state and watchdog counter widths
//   decode_region() : fixed-priority select decode
package bus_cycle_responder_pkg;

  localparam int WAIT_W = 4;
  localparam int TMO_W  = 10;
  localparam logic [TMO_W-1:0] TMO_MAX = '1;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    ACK,
    BERR
  } state_t;

  typedef enum logic [2:0] {
    REG_NONE,
    REG_ROM,
    REG_RAM,
    REG_IO,
    REG_DRAM,
    REG_CAN,
    REG_OFFBOARD
  } region_t;

  // ROM > RAM > IO > DRAM > CAN > OffBoard > none
  function automatic region_t decode_region(input logic rom, input logic ram,
                                            input logic io, input logic dram,
                                            input logic can, input logic off);
    region_t r;
    if (rom)       r = REG_ROM;
    else if (ram)  r = REG_RAM;
    else if (io)   r = REG_IO;
    else if (dram) r = REG_DRAM;
    else if (can)  r = REG_CAN;
    else if (off)  r = REG_OFFBOARD;
    else           r = REG_NONE;
    return r;
  endfunction

endpackage

// File: rtl/bus_cycle_responder_timeout.sv
// bus_timeout_counter: saturating watchdog counter for unanswered bus cycles.
// Ports:
//   clk_i, rst_i : clock, asynchronous active-high reset
//   clr_i        : synchronous clear (priority over enable)
//   en_i         : count one per clock while high; holds at all-ones
//   tc_val_i     : terminal count compare value
//   tc_o         : high while the registered count equals tc_val_i
module bus_timeout_counter
  import bus_cycle_responder_pkg::*;
(
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             clr_i,
  input  logic             en_i,
  input  logic [TMO_W-1:0] tc_val_i,
  output logic             tc_o
);

  logic [TMO_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i && (cnt_q != TMO_MAX)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

  assign tc_o = (cnt_q == tc_val_i);

endmodule

// File: rtl/bus_cycle_responder.sv
// bus_cycle_responder: completes 68000 bus cycles steered to a region by the
// address decoder, driving DTACK_L (with per-region wait states for on-chip
// ROM/RAM/IO, or forwarded from external responders) and BERR_L (watchdog).
// Optional feature macro: BUS_CYCLE_RESPONDER_BERR_EN enables the watchdog
// counter and BERR state; otherwise BErrOut_L is tied high.
// Ports:
//   Clk, Reset_H          : clock, asynchronous active-high reset
//   AS_L, UDS_L, LDS_L    : CPU address / data strobes
//   *Select_H, OffBoardMemory_H : decoder region selects
//   SdramDtack_L, CanDtack_L, OffBoardDtack_L : external acknowledges
//   DtackOut_L, BErrOut_L : CPU handshake outputs (decoded from state reg)
//   Busy_H                : high whenever the FSM is not IDLE
module bus_cycle_responder
  import bus_cycle_responder_pkg::*;
#(
  parameter int ROM_WAIT     = 0,
  parameter int RAM_WAIT     = 1,
  parameter int IO_WAIT      = 2,
  parameter int BERR_TIMEOUT = 255
) (
  input  logic Clk,
  input  logic Reset_H,
  input  logic AS_L,
  input  logic UDS_L,
  input  logic LDS_L,
  input  logic OnChipRomSelect_H,
  input  logic OnChipRamSelect_H,
  input  logic IOSelect_H,
  input  logic DramSelect_H,
  input  logic CanBusSelect_H,
  input  logic OffBoardMemory_H,
  input  logic SdramDtack_L,
  input  logic CanDtack_L,
  input  logic OffBoardDtack_L,
  output logic DtackOut_L,
  output logic BErrOut_L,
  output logic Busy_H
);

  // Elaboration-time range checks on the configuration parameters.
  if (ROM_WAIT < 0 || ROM_WAIT > 15) begin : g_bad_rom_wait
    $error("ROM_WAIT out of range 0..15");
  end
  if (RAM_WAIT < 0 || RAM_WAIT > 15) begin : g_bad_ram_wait
    $error("RAM_WAIT out of range 0..15");
  end
  if (IO_WAIT < 0 || IO_WAIT > 15) begin : g_bad_io_wait
    $error("IO_WAIT out of range 0..15");
  end
  if (BERR_TIMEOUT < 1 || BERR_TIMEOUT > 1023) begin : g_bad_tmo
    $error("BERR_TIMEOUT out of range 1..1023");
  end

  state_t              state_q, state_d;
  region_t             region_q, region_d;
  logic [WAIT_W-1:0]   wait_q, wait_d;

  logic strobe;
  logic internal;
  logic ext_ack;
  logic ack_due;

  assign strobe   = !AS_L && (!UDS_L || !LDS_L);
  assign internal = (region_q == REG_ROM) || (region_q == REG_RAM) ||
                    (region_q == REG_IO);

  // Only the acknowledge belonging to the latched region is honoured.
  always_comb begin
    ext_ack = 1'b0;
    case (region_q)
      REG_DRAM:     ext_ack = !SdramDtack_L;
      REG_CAN:      ext_ack = !CanDtack_L;
      REG_OFFBOARD: ext_ack = !OffBoardDtack_L;
      default:      ext_ack = 1'b0;
    endcase
  end

  // REG_NONE is neither internal nor has an external ack, so it never acks.
  assign ack_due = internal ? (wait_q == '0) : ext_ack;

  function automatic logic [WAIT_W-1:0] wait_load(input region_t r);
    logic [WAIT_W-1:0] w;
    case (r)
      REG_ROM: w = WAIT_W'(ROM_WAIT);
      REG_RAM: w = WAIT_W'(RAM_WAIT);
      REG_IO:  w = WAIT_W'(IO_WAIT);
      default: w = '0;
    endcase
    return w;
  endfunction

`ifdef BUS_CYCLE_RESPONDER_BERR_EN
  localparam logic [TMO_W-1:0] TMO_VAL = TMO_W'(BERR_TIMEOUT);

  logic tmo_clr;
  logic tmo_en;
  logic tmo_tc;

  bus_timeout_counter u_tmo (
    .clk_i    (Clk),
    .rst_i    (Reset_H),
    .clr_i    (tmo_clr),
    .en_i     (tmo_en),
    .tc_val_i (TMO_VAL),
    .tc_o     (tmo_tc)
  );
`endif

  always_comb begin
    state_d  = state_q;
    region_d = region_q;
    wait_d   = wait_q;
`ifdef BUS_CYCLE_RESPONDER_BERR_EN
    tmo_clr  = 1'b0;
    tmo_en   = 1'b0;
`endif
    case (state_q)
      IDLE: begin
        if (strobe) begin
          state_d  = WAIT;
          region_d = decode_region(OnChipRomSelect_H, OnChipRamSelect_H,
                                   IOSelect_H, DramSelect_H,
                                   CanBusSelect_H, OffBoardMemory_H);
          wait_d   = wait_load(region_d);
`ifdef BUS_CYCLE_RESPONDER_BERR_EN
          tmo_clr  = 1'b1;
`endif
        end
      end
      WAIT: begin
`ifdef BUS_CYCLE_RESPONDER_BERR_EN
        tmo_en = 1'b1;
`endif
        if (internal && (wait_q != '0)) wait_d = wait_q - 1'b1;
        // Abort beats acknowledge, which beats the watchdog.
        if (AS_L) begin
          state_d = IDLE;
        end else if (ack_due) begin
          state_d = ACK;
        end
`ifdef BUS_CYCLE_RESPONDER_BERR_EN
        else if (tmo_tc) begin
          state_d = BERR;
        end
`endif
      end
      ACK: begin
        if (AS_L) state_d = IDLE;
      end
      BERR: begin
        if (AS_L) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge Clk or posedge Reset_H) begin
    if (Reset_H) begin
      state_q  <= IDLE;
      region_q <= REG_NONE;
      wait_q   <= '0;
    end else begin
      state_q  <= state_d;
      region_q <= region_d;
      wait_q   <= wait_d;
    end
  end

  // One-hot state decode keeps DTACK and BERR mutually exclusive.
  assign DtackOut_L = (state_q != ACK);
`ifdef BUS_CYCLE_RESPONDER_BERR_EN
  assign BErrOut_L  = (state_q != BERR);
`else
  assign BErrOut_L  = 1'b1;
`endif
  assign Busy_H     = (state_q != IDLE);

endmodule

// File: tb/tb_bus_cycle_responder.sv
module tb_bus_cycle_responder;

  logic Clk = 1'b0;
  logic Reset_H;
  logic AS_L, UDS_L, LDS_L;
  logic OnChipRomSelect_H, OnChipRamSelect_H, IOSelect_H;
  logic DramSelect_H, CanBusSelect_H, OffBoardMemory_H;
  logic SdramDtack_L, CanDtack_L, OffBoardDtack_L;
  logic DtackOut_L, BErrOut_L, Busy_H;

  int pass_cnt  = 0;
  int total_cnt = 0;

  always #5 Clk = ~Clk;

  bus_cycle_responder #(
    .ROM_WAIT     (0),
    .RAM_WAIT     (3),
    .IO_WAIT      (2),
    .BERR_TIMEOUT (4)
  ) dut (
    .Clk               (Clk),
    .Reset_H           (Reset_H),
    .AS_L              (AS_L),
    .UDS_L             (UDS_L),
    .LDS_L             (LDS_L),
    .OnChipRomSelect_H (OnChipRomSelect_H),
    .OnChipRamSelect_H (OnChipRamSelect_H),
    .IOSelect_H        (IOSelect_H),
    .DramSelect_H      (DramSelect_H),
    .CanBusSelect_H    (CanBusSelect_H),
    .OffBoardMemory_H  (OffBoardMemory_H),
    .SdramDtack_L      (SdramDtack_L),
    .CanDtack_L        (CanDtack_L),
    .OffBoardDtack_L   (OffBoardDtack_L),
    .DtackOut_L        (DtackOut_L),
    .BErrOut_L         (BErrOut_L),
    .Busy_H            (Busy_H)
  );

  // Inputs change and outputs are sampled on the falling edge.
  task automatic tick();
    @(negedge Clk);
  endtask

  task automatic bus_idle();
    AS_L = 1'b1; UDS_L = 1'b1; LDS_L = 1'b1;
    OnChipRomSelect_H = 1'b0; OnChipRamSelect_H = 1'b0; IOSelect_H = 1'b0;
    DramSelect_H = 1'b0; CanBusSelect_H = 1'b0; OffBoardMemory_H = 1'b0;
    SdramDtack_L = 1'b1; CanDtack_L = 1'b1; OffBoardDtack_L = 1'b1;
  endtask

  task automatic test_reset();
    Reset_H = 1'b1;
    bus_idle();
    tick(); tick();
    total_cnt++;
    if ({DtackOut_L, BErrOut_L, Busy_H} !== 3'b110)
      $display("FAIL reset: dtack=%b berr=%b busy=%b required 1 1 0",
               DtackOut_L, BErrOut_L, Busy_H);
    else pass_cnt++;
    Reset_H = 1'b0;
    tick();
  endtask

  task automatic test_rom();
    OnChipRomSelect_H = 1'b1; AS_L = 1'b0; LDS_L = 1'b0;  // edge 0
    tick();
    total_cnt++;
    if (DtackOut_L !== 1'b1 || Busy_H !== 1'b1)
      $display("FAIL rom_e0: dtack=%b busy=%b required 1 1", DtackOut_L, Busy_H);
    else pass_cnt++;
    tick();
    total_cnt++;
    if (DtackOut_L !== 1'b0)
      $display("FAIL rom_e1: dtack=%b required 0", DtackOut_L);
    else pass_cnt++;
    tick(); tick(); tick();
    total_cnt++;
    if (DtackOut_L !== 1'b0 || BErrOut_L !== 1'b1)
      $display("FAIL rom_hold_e4: dtack=%b berr=%b required 0 1", DtackOut_L, BErrOut_L);
    else pass_cnt++;
    AS_L = 1'b1; LDS_L = 1'b1;                            // edge 5
    tick();
    total_cnt++;
    if (DtackOut_L !== 1'b1 || Busy_H !== 1'b0)
      $display("FAIL rom_release_e5: dtack=%b busy=%b required 1 0", DtackOut_L, Busy_H);
    else pass_cnt++;
    bus_idle();
    tick();
  endtask

  task automatic test_priority();
    OnChipRomSelect_H = 1'b1; IOSelect_H = 1'b1; AS_L = 1'b0; UDS_L = 1'b0;
    tick(); tick();
    total_cnt++;
    if (DtackOut_L !== 1'b0)
      $display("FAIL prio_rom_over_io: dtack=%b required 0 after edge 1", DtackOut_L);
    else pass_cnt++;
    bus_idle();
    tick(); tick();
  endtask

  task automatic test_io();
    IOSelect_H = 1'b1; AS_L = 1'b0; UDS_L = 1'b0; LDS_L = 1'b0;
    tick();
    // Region is frozen: swapping selects mid-cycle must not shorten it.
    IOSelect_H = 1'b0; OnChipRomSelect_H = 1'b1;
    for (int e = 1; e <= 3; e++) begin
      tick();
      total_cnt++;
      if (DtackOut_L !== ((e == 3) ? 1'b0 : 1'b1))
        $display("FAIL io_wait_e%0d: dtack=%b required %b", e, DtackOut_L,
                 (e == 3) ? 1'b0 : 1'b1);
      else pass_cnt++;
    end
    bus_idle();
    tick(); tick();
  endtask

  task automatic test_dram();
    DramSelect_H = 1'b1; AS_L = 1'b0; LDS_L = 1'b0;
    tick();
    for (int e = 1; e <= 7; e++) begin
      CanDtack_L   = (e == 2 || e == 3) ? 1'b0 : 1'b1;
      SdramDtack_L = (e == 7) ? 1'b0 : 1'b1;
      tick();
      total_cnt++;
      if (DtackOut_L !== ((e == 7) ? 1'b0 : 1'b1))
        $display("FAIL dram_e%0d: dtack=%b required %b", e, DtackOut_L,
                 (e == 7) ? 1'b0 : 1'b1);
      else pass_cnt++;
    end
    bus_idle();
    tick();
    total_cnt++;
    if (DtackOut_L !== 1'b1 || Busy_H !== 1'b0)
      $display("FAIL dram_release: dtack=%b busy=%b required 1 0", DtackOut_L, Busy_H);
    else pass_cnt++;
    tick();
  endtask

  task automatic test_none();
    AS_L = 1'b0; UDS_L = 1'b0;
    tick();
`ifdef BUS_CYCLE_RESPONDER_BERR_EN
    for (int e = 1; e <= 5; e++) begin
      tick();
      total_cnt++;
      if (BErrOut_L !== ((e == 5) ? 1'b0 : 1'b1) || DtackOut_L !== 1'b1)
        $display("FAIL none_berr_e%0d: berr=%b dtack=%b required %b 1", e,
                 BErrOut_L, DtackOut_L, (e == 5) ? 1'b0 : 1'b1);
      else pass_cnt++;
    end
`else
    for (int e = 1; e <= 8; e++) begin
      tick();
      total_cnt++;
      if (BErrOut_L !== 1'b1 || DtackOut_L !== 1'b1 || Busy_H !== 1'b1)
        $display("FAIL none_wait_e%0d: berr=%b dtack=%b busy=%b required 1 1 1", e,
                 BErrOut_L, DtackOut_L, Busy_H);
      else pass_cnt++;
    end
`endif
    bus_idle();
    tick();
    total_cnt++;
    if (BErrOut_L !== 1'b1 || Busy_H !== 1'b0)
      $display("FAIL none_release: berr=%b busy=%b required 1 0", BErrOut_L, Busy_H);
    else pass_cnt++;
    tick();
  endtask

  task automatic test_abort();
    OnChipRamSelect_H = 1'b1; AS_L = 1'b0; LDS_L = 1'b0;
    tick(); tick();
    AS_L = 1'b1;                                          // edge 2
    tick();
    total_cnt++;
    if (Busy_H !== 1'b0 || DtackOut_L !== 1'b1)
      $display("FAIL abort_e2: busy=%b dtack=%b required 0 1", Busy_H, DtackOut_L);
    else pass_cnt++;
    tick(); tick();
    total_cnt++;
    if (DtackOut_L !== 1'b1)
      $display("FAIL abort_no_late_ack: dtack=%b required 1", DtackOut_L);
    else pass_cnt++;
    AS_L = 1'b0;                                          // fresh RAM cycle
    tick();
    for (int e = 1; e <= 4; e++) begin
      tick();
      total_cnt++;
      if (DtackOut_L !== ((e == 4) ? 1'b0 : 1'b1))
        $display("FAIL after_abort_e%0d: dtack=%b required %b", e, DtackOut_L,
                 (e == 4) ? 1'b0 : 1'b1);
      else pass_cnt++;
    end
    bus_idle();
    tick(); tick();
  endtask

  task automatic test_reset_mid();
    OnChipRomSelect_H = 1'b1; AS_L = 1'b0; LDS_L = 1'b0;
    tick(); tick();
    total_cnt++;
    if (DtackOut_L !== 1'b0)
      $display("FAIL rstmid_in_ack: dtack=%b required 0", DtackOut_L);
    else pass_cnt++;
    #2 Reset_H = 1'b1;
    #1;
    total_cnt++;
    if (DtackOut_L !== 1'b1 || Busy_H !== 1'b0)
      $display("FAIL rstmid_async: dtack=%b busy=%b required 1 0", DtackOut_L, Busy_H);
    else pass_cnt++;
    bus_idle();
    tick();
    Reset_H = 1'b0;
    tick();
    OnChipRomSelect_H = 1'b1; AS_L = 1'b0; LDS_L = 1'b0;
    tick(); tick();
    total_cnt++;
    if (DtackOut_L !== 1'b0)
      $display("FAIL rstmid_next_cycle: dtack=%b required 0", DtackOut_L);
    else pass_cnt++;
    bus_idle();
    tick(); tick();
  endtask

  task automatic test_back_to_back();
    OnChipRomSelect_H = 1'b1; AS_L = 1'b0; LDS_L = 1'b0;
    tick(); tick();
    AS_L = 1'b1; LDS_L = 1'b1;                            // edge R
    tick();
    total_cnt++;
    if (Busy_H !== 1'b0 || DtackOut_L !== 1'b1)
      $display("FAIL b2b_idle: busy=%b dtack=%b required 0 1", Busy_H, DtackOut_L);
    else pass_cnt++;
    AS_L = 1'b0; UDS_L = 1'b0;                            // edge R+1
    tick();
    total_cnt++;
    if (Busy_H !== 1'b1 || DtackOut_L !== 1'b1)
      $display("FAIL b2b_accept: busy=%b dtack=%b required 1 1", Busy_H, DtackOut_L);
    else pass_cnt++;
    tick();
    total_cnt++;
    if (DtackOut_L !== 1'b0)
      $display("FAIL b2b_ack: dtack=%b required 0", DtackOut_L);
    else pass_cnt++;
    bus_idle();
    tick(); tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_rom();
    test_priority();
    test_io();
    test_dram();
    test_none();
    test_abort();
    test_reset_mid();
    test_back_to_back();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/bus_cycle_responder.md
# bus_cycle_responder

Completes every 68000 bus cycle that the address decoder has steered to a region by driving the CPU's DTACK_L and BERR_L handshake. It sits between the decoder's select outputs and the CPU. It inserts per-region wait states for on-chip ROM, RAM and IO, and forwards the acknowledge from slow external responders (SDRAM controller, CAN controller, off-board memory). A watchdog raises bus error on unanswered cycles.

## Interface
Parameters:
- ROM_WAIT, 0, wait states before DTACK for on-chip ROM cycles (0–15)
- RAM_WAIT, 1, wait states for on-chip RAM cycles (0–15)
- IO_WAIT, 2, wait states for IO cycles (0–15)
- BERR_TIMEOUT, 255, cycles in WAIT before bus error (1–1023)

Ports:
- Clk  in  1  system clock; all inputs synchronous to it
- Reset_H  in  1  asynchronous, active-high reset
- AS_L  in  1  CPU address strobe
- UDS_L, LDS_L  in  1 each  CPU data strobes
- OnChipRomSelect_H, OnChipRamSelect_H, IOSelect_H, DramSelect_H, CanBusSelect_H, OffBoardMemory_H  in  1 each  decoder selects
- SdramDtack_L, CanDtack_L, OffBoardDtack_L  in  1 each  external responder acknowledges
- DtackOut_L  out  1  to CPU DTACK_L, registered
- BErrOut_L  out  1  to CPU BERR_L, registered
- Busy_H  out  1  high while a cycle is being serviced (not IDLE)

## Operation
- States: IDLE, WAIT, ACK, BERR.
- IDLE: at an edge where AS_L=0 and (UDS_L=0 or LDS_L=0), latch the region and go to WAIT.
  - Region priority when several selects are high: ROM > RAM > IO > DRAM > CAN > OffBoard > none.
  - For internal regions (ROM, RAM, IO), load the wait counter with the region's parameter.
  - Clear the timeout counter.
- The region is frozen for the whole cycle. Select changes after latching are ignored.
- WAIT, internal region: if wait count = 0 → ACK; else decrement.
- WAIT, external region: when the matching external DTACK_L is sampled low → ACK. The other external inputs are ignored.
- WAIT, region none: no acknowledge is ever produced. Only the timeout can end the cycle.
- WAIT, timeout: increment the counter every cycle. When count = BERR_TIMEOUT and ACK was not reached on that edge → BERR. ACK wins if both are due on the same edge.
- WAIT, abort: AS_L sampled high → IDLE with no acknowledge. This has priority over ACK and BERR.
- ACK: DtackOut_L=0 until AS_L is sampled high → IDLE.
- BERR: BErrOut_L=0 until AS_L is sampled high → IDLE.
- Outputs are decoded from the registered state. DtackOut_L and BErrOut_L are never low together.
- Wait counter is 4 bits. Timeout counter is 10 bits and saturates; it never wraps.

## Timing
- Reset values: state IDLE, DtackOut_L=1, BErrOut_L=1, Busy_H=0, counters 0.
- Reset asserted mid-cycle forces the reset values immediately (asynchronously).
- Internal region: strobe sampled at edge N → DtackOut_L low after edge N+1+W, where W is the region's wait parameter. ROM with default W=0 → DTACK low one cycle after the strobe edge.
- External region: external DTACK_L sampled low at edge M → DtackOut_L low after edge M.
- Release: AS_L sampled high at edge R → DtackOut_L and BErrOut_L high after edge R.
- A new strobe is accepted no earlier than the edge after the return to IDLE. Back-to-back cycles therefore need at least one IDLE cycle.

## Configuration
- Macro: BUS_CYCLE_RESPONDER_BERR_EN.
- Defined: timeout counter and BERR state are present, behaving as described above.
- Undefined:
  - No timeout counter and no BERR state; BErrOut_L is tied to 1.
  - Region-none cycles stay in WAIT until AS_L negates.
  - The BERR_TIMEOUT parameter is accepted but unused.

## Structure
- Package bus_cycle_responder_pkg holds:
  - state enum {IDLE, WAIT, ACK, BERR}
  - region enum {REG_NONE, REG_ROM, REG_RAM, REG_IO, REG_DRAM, REG_CAN, REG_OFFBOARD}
  - counter width constants
- One sub-module, bus_timeout_counter: a saturating 10-bit counter with clear, enable and terminal-count compare. It is instantiated only under BUS_CYCLE_RESPONDER_BERR_EN.

## Test plan
- ROM read, defaults: AS_L and LDS_L low at edge 0 with OnChipRomSelect_H=1 → DtackOut_L low after edge 1; AS_L high at edge 5 → DtackOut_L high after edge 5.
- IO cycle with IO_WAIT=2 and OnChipRomSelect_H also high → ROM wins, DTACK after edge 1; repeat with only IOSelect_H → DTACK after edge 3.
- DRAM cycle with SdramDtack_L low at edge 7 → DtackOut_L low after edge 7; CanDtack_L pulsing low earlier has no effect.
- No select, BERR_EN defined, BERR_TIMEOUT=4 → BErrOut_L low after edge 5, DtackOut_L stays 1; macro undefined → both stay 1 until AS_L negates.
- Abort: RAM cycle with RAM_WAIT=3, AS_L high at edge 2 → no DTACK, Busy_H low after edge 2; next strobe is accepted normally.
- Reset_H pulsed while in ACK → DtackOut_L=1 immediately, state IDLE, next cycle served correctly.
